// File: rtl/clock_reset_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_reset_ctrl_if
// Description : Groups the PLL-lock input and the reset/enable outputs of
//               clock_reset_ctrl.
//               slave  : the controller (consumes locked, drives the rest)
//               master : the PLL / system side
//   locked       : PLL lock, asynchronous to clk
//   sys_rst      : core reset, active-high
//   ready        : inverse of sys_rst
//   cen_0, cen_1 : single-cycle fractional clock enables
//   relock_count : saturating count of lock losses while running
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_reset_ctrl_if;
   logic       locked;
   logic       sys_rst;
   logic       ready;
   logic       cen_0;
   logic       cen_1;
   logic [7:0] relock_count;

   modport slave (
      input  locked,
      output sys_rst, ready, cen_0, cen_1, relock_count
   );

   modport master (
      output locked,
      input  sys_rst, ready, cen_0, cen_1, relock_count
   );
endinterface
`default_nettype wire

// File: rtl/clock_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_reset_ctrl
// Description : Holds the core in reset until the PLL lock has been stable
//               for LOCK_STABLE_CYCLES synchronized cycles, then releases it
//               and generates two fractional clock enables (rate MUL/DIV).
//               Loss of lock re-asserts reset and is counted.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - clock_reset_ctrl_if.slave (locked in; sys_rst, ready,
//                      cen_0, cen_1, relock_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module clock_reset_ctrl #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CEN0_MUL           = 1,
   parameter int CEN0_DIV           = 8,
   parameter int CEN1_MUL           = 1,
   parameter int CEN1_DIV           = 12
) (
   input  wire logic        clk,
   input  wire logic        rst,
   clock_reset_ctrl_if.slave bus
);

   localparam int c_cnt_w  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int c_acc0_w = $clog2(CEN0_DIV + CEN0_MUL);
   localparam int c_acc1_w = $clog2(CEN1_DIV + CEN1_MUL);

   localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
   localparam logic [c_acc0_w-1:0] c_mul0     = c_acc0_w'(CEN0_MUL);
   localparam logic [c_acc0_w-1:0] c_div0     = c_acc0_w'(CEN0_DIV);
   localparam logic [c_acc1_w-1:0] c_mul1     = c_acc1_w'(CEN1_MUL);
   localparam logic [c_acc1_w-1:0] c_div1     = c_acc1_w'(CEN1_DIV);

   localparam logic [1:0] c_st_hold  = 2'd0;
   localparam logic [1:0] c_st_count = 2'd1;
   localparam logic [1:0] c_st_run   = 2'd2;

   logic                lk_meta_q, lk_s_q;
   logic [1:0]          state_q, state_d;
   logic [c_cnt_w-1:0]  cnt_q, cnt_d;
   logic                sys_rst_q, sys_rst_d;
   logic                ready_q, ready_d;
   logic [7:0]          relock_q, relock_d;
   logic                run_keep;
   logic [c_acc0_w-1:0] acc0_q, acc0_d, sum0;
   logic [c_acc1_w-1:0] acc1_q, acc1_d, sum1;
   logic                cen0_q, cen0_d, cen1_q, cen1_d;

   // Two-flop synchronizer for the asynchronous lock input
   always_ff @(posedge clk) begin
      if (rst) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
      end else begin
         lk_meta_q <= bus.locked;
         lk_s_q    <= lk_meta_q;
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_st_hold;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM: next state and stability counter
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         c_st_hold: begin
            if (lk_s_q) state_d = c_st_count;
         end
         c_st_count: begin
            if (!lk_s_q) begin
               state_d = c_st_hold;
            end else if (cnt_q == c_cnt_last) begin
               state_d = c_st_run;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         c_st_run: begin
            if (!lk_s_q) state_d = c_st_hold;
         end
         default: state_d = c_st_hold;
      endcase
   end

   // FSM: outputs. Everything is registered from the next state so that the
   // enables drop on exactly the edge that re-asserts sys_rst.
   always_comb begin
      run_keep  = (state_q == c_st_run) && (state_d == c_st_run);
      sys_rst_d = (state_d != c_st_run);
      ready_d   = (state_d == c_st_run);
      relock_d  = relock_q;
      if ((state_q == c_st_run) && (state_d != c_st_run) && (relock_q != 8'hFF))
         relock_d = relock_q + 8'd1;
   end

   // Fractional enable accumulators: add MUL, wrap at DIV, pulse on wrap
   always_comb begin
      sum0   = acc0_q + c_mul0;
      acc0_d = '0;
      cen0_d = 1'b0;
      if (run_keep) begin
         if (sum0 >= c_div0) begin
            acc0_d = sum0 - c_div0;
            cen0_d = 1'b1;
         end else begin
            acc0_d = sum0;
         end
      end
   end

   always_comb begin
      sum1   = acc1_q + c_mul1;
      acc1_d = '0;
      cen1_d = 1'b0;
      if (run_keep) begin
         if (sum1 >= c_div1) begin
            acc1_d = sum1 - c_div1;
            cen1_d = 1'b1;
         end else begin
            acc1_d = sum1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         relock_q  <= 8'd0;
         acc0_q    <= '0;
         acc1_q    <= '0;
         cen0_q    <= 1'b0;
         cen1_q    <= 1'b0;
      end else begin
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         relock_q  <= relock_d;
         acc0_q    <= acc0_d;
         acc1_q    <= acc1_d;
         cen0_q    <= cen0_d;
         cen1_q    <= cen1_d;
      end
   end

   assign bus.sys_rst      = sys_rst_q;
   assign bus.ready        = ready_q;
   assign bus.cen_0        = cen0_q;
   assign bus.cen_1        = cen1_q;
   assign bus.relock_count = relock_q;

endmodule
`default_nettype wire
